// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus word-memory port bundle for mem_access_unit.
// slave = the access unit itself; master = requester and memory side.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [31:0] mem_address;
  logic        mem_write;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  rsp_ready, mem_read_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_error,
    output mem_address, mem_write, mem_write_data
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output rsp_ready, mem_read_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error,
    input  mem_address, mem_write, mem_write_data
  );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store unit in front of a single-port word memory.
// Define MISALIGN_TRAP_EN to reject misaligned half/word accesses instead of ignoring low address bits.
module mem_access_unit #(
  parameter int MEM_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  mem_access_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, STORE, RESP} state_t;

  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

  state_t      state, state_nxt;
  logic        wr_q;
  logic        sgn_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] old_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        req_err;

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      2'b10:   r = word;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Only the addressed lanes of the previously read word are replaced.
  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] off);
    logic [31:0] r;
    r = old;
    case (size)
      2'b00:   r[{off, 3'b000} +: 8]     = wdata[7:0];
      2'b01:   r[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: r = wdata;
    endcase
    return r;
  endfunction

  always_comb begin
    req_err = (bus.req_size == 2'b11) || ({1'b0, bus.req_addr} >= ADDR_LIMIT);
`ifdef MISALIGN_TRAP_EN
    if ((bus.req_size == 2'b01 && bus.req_addr[0]) ||
        (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00))
      req_err = 1'b1;
`endif
  end

  always_comb begin
    state_nxt          = state;
    bus.req_ready      = 1'b0;
    bus.rsp_valid      = 1'b0;
    bus.mem_address    = '0;
    bus.mem_write      = 1'b0;
    bus.mem_write_data = '0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (req_err)
            state_nxt = RESP;
          else if (bus.req_write && bus.req_size == 2'b10)
            state_nxt = STORE;
          else
            state_nxt = LOAD;
        end
      end
      LOAD: begin
        bus.mem_address = {addr_q[31:2], 2'b00};
        state_nxt       = wr_q ? STORE : RESP;
      end
      STORE: begin
        bus.mem_address    = {addr_q[31:2], 2'b00};
        bus.mem_write      = !reset;
        bus.mem_write_data = store_merge(old_q, wdata_q, size_q, addr_q[1:0]);
        state_nxt          = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_error = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      wr_q    <= 1'b0;
      sgn_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      old_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (bus.req_valid) begin
          wr_q    <= bus.req_write;
          sgn_q   <= bus.req_signed;
          size_q  <= bus.req_size;
          addr_q  <= bus.req_addr;
          wdata_q <= bus.req_wdata;
          rdata_q <= '0;
          err_q   <= req_err;
        end
        // A sub-word store reuses the LOAD cycle to fetch the word it will merge into.
        LOAD: begin
          if (wr_q)
            old_q <= bus.mem_read_data;
          else
            rdata_q <= load_extract(bus.mem_read_data, size_q, addr_q[1:0], sgn_q);
        end
        default: ;
      endcase
    end
  end

endmodule
